// File: rtl/kanagawa_hal_gray_pkg.sv
// Shared types and Gray-code helpers for the Gray pointer receiver.
package kanagawa_hal_gray_pkg;

    localparam int unsigned MaxWidth = 32;

    typedef enum logic [1:0] {PRIME, BASE, RUN} gray_rx_state_t;

    // Helpers work on a max-width vector; bits at and above w are forced to zero.
    function automatic logic [MaxWidth-1:0] width_mask(input int unsigned w);
        logic [MaxWidth-1:0] m;
        m = '0;
        for (int i = 0; i < MaxWidth; i++) begin
            if (i < w) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [MaxWidth-1:0] gray2bin(input logic [MaxWidth-1:0] g,
                                                     input int unsigned w);
        logic [MaxWidth-1:0] gm;
        logic [MaxWidth-1:0] b;
        gm = g & width_mask(w);
        b  = '0;
        for (int i = 0; i < MaxWidth; i++) begin
            b[i] = ^(gm >> i);
        end
        return b;
    endfunction

    function automatic logic [MaxWidth-1:0] bin2gray(input logic [MaxWidth-1:0] b,
                                                     input int unsigned w);
        logic [MaxWidth-1:0] bm;
        bm = b & width_mask(w);
        return bm ^ (bm >> 1);
    endfunction

endpackage

// File: rtl/kanagawa_hal_gray_ptr_receiver_if.sv
// Pointer input, decoded pointer and count valid/ready stream of the Gray pointer receiver.
interface kanagawa_hal_gray_ptr_receiver_if #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ACC_WIDTH = 16
);
    logic [WIDTH-1:0]     gray_in;
    logic [WIDTH-1:0]     bin_out;
    logic                 count_valid;
    logic                 count_ready;
    logic [ACC_WIDTH-1:0] count_data;
    logic                 acc_sat;
    logic                 step_err;

    // master: the receiver itself; slave: the sync chain and count consumer around it
    modport master (
        input  gray_in,
        input  count_ready,
        output bin_out,
        output count_valid,
        output count_data,
        output acc_sat,
        output step_err
    );

    modport slave (
        output gray_in,
        output count_ready,
        input  bin_out,
        input  count_valid,
        input  count_data,
        input  acc_sat,
        input  step_err
    );
endinterface

// File: rtl/kanagawa_hal_gray_to_bin.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of all Gray bits at or above it.
module kanagawa_hal_gray_to_bin #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);
    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end
endmodule

// File: rtl/kanagawa_hal_gray_ptr_receiver.sv
// Registers a synchronized Gray pointer, decodes it and accumulates its advance as a count stream.
// Optional Gray step checking is enabled by defining KANAGAWA_HAL_GRAY_STEP_CHECK_EN.
module kanagawa_hal_gray_ptr_receiver
    import kanagawa_hal_gray_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ACC_WIDTH = 16
) (
    input logic                            clk,
    input logic                            rst,
    kanagawa_hal_gray_ptr_receiver_if.master bus
);

    initial begin
        if (WIDTH < 2 || WIDTH > 32) $error("WIDTH must be in 2..32, got %0d", WIDTH);
        if (ACC_WIDTH < WIDTH) $error("ACC_WIDTH (%0d) must be >= WIDTH (%0d)", ACC_WIDTH, WIDTH);
    end

    gray_rx_state_t       state_q, state_d;
    logic [WIDTH-1:0]     gray_q;
    logic [WIDTH-1:0]     bin_q, bin_d;
    logic [WIDTH-1:0]     b;
    logic [WIDTH-1:0]     delta;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH:0]   sum;
    logic                 valid_q;
    logic                 sat_q, sat_d;
    logic                 accept;

    kanagawa_hal_gray_to_bin #(
        .WIDTH (WIDTH)
    ) u_decode (
        .gray (gray_q),
        .bin  (b)
    );

    // Modulo-2^WIDTH subtraction makes a wrap from all-ones to zero count as one step.
    assign delta  = b - bin_q;
    assign sum    = {1'b0, acc_q} + (ACC_WIDTH + 1)'(delta);
    assign accept = valid_q & bus.count_ready;

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        sat_d   = sat_q;
        unique case (state_q)
            PRIME: state_d = BASE;
            BASE: begin
                bin_d   = b;
                state_d = RUN;
            end
            RUN: begin
                bin_d = b;
                if (accept) begin
                    // The delta landing in the accept cycle seeds the next count.
                    acc_d = ACC_WIDTH'(delta);
                end else if (sum[ACC_WIDTH]) begin
                    acc_d = '1;
                    sat_d = 1'b1;
                end else begin
                    acc_d = sum[ACC_WIDTH-1:0];
                end
            end
            default: state_d = PRIME;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PRIME;
            gray_q  <= '0;
            bin_q   <= '0;
            acc_q   <= '0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gray_q  <= bus.gray_in;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            valid_q <= (acc_d != '0);
            sat_q   <= sat_d;
        end
    end

    assign bus.bin_out     = bin_q;
    assign bus.count_valid = valid_q;
    assign bus.count_data  = acc_q;
    assign bus.acc_sat     = sat_q;

`ifdef KANAGAWA_HAL_GRAY_STEP_CHECK_EN
    logic [WIDTH-1:0] diff;
    logic [5:0]       ones;
    logic             step_q, step_d;

    assign diff = bus.gray_in ^ gray_q;

    always_comb begin
        ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + 6'(diff[i]);
        end
        step_d = step_q | ((state_q == RUN) && (ones > 6'd1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) step_q <= 1'b0;
        else     step_q <= step_d;
    end

    assign bus.step_err = step_q;

`ifndef SYNTHESIS
    step_check: assert property (@(posedge clk) disable iff (rst)
        (state_q == RUN) |-> ($countones(bus.gray_in ^ gray_q) <= 1))
        else $warning("gray pointer moved more than one bit in a cycle");
`endif
`else
    assign bus.step_err = 1'b0;
`endif

endmodule
